// File: rtl/money_bcd_scheduler.sv
// Per-frame binary-to-BCD converter for the money overlay: one shared double-dabble engine, atomic commit.
// Optional leading-zero blanking is enabled by defining MONEY_BCD_LEADING_BLANK_EN.
module money_bcd_scheduler #(
    parameter int unsigned VAL_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [VAL_W-1:0] player_stacks [2],
    input  logic [VAL_W-1:0] player_pots   [2],
    input  logic [VAL_W-1:0] pot_size,
    input  logic             current_player,
    output logic [15:0]      your_stack_bcd,
    output logic [15:0]      other_stack_bcd,
    output logic [15:0]      your_pot_bcd,
    output logic [15:0]      other_pot_bcd,
    output logic [15:0]      total_pot_bcd,
    output logic [3:0]       your_stack_blank,
    output logic [3:0]       other_stack_blank,
    output logic [3:0]       your_pot_blank,
    output logic [3:0]       other_pot_blank,
    output logic [3:0]       total_pot_blank,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NSLOT  = 5;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned CNT_W  = $clog2(VAL_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

    state_e             state_q, state_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VAL_W-1:0]   bin_q, bin_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [VAL_W-1:0]   snap_q   [NSLOT];
    logic [VAL_W-1:0]   snap_d   [NSLOT];
    logic [15:0]        shadow_q [NSLOT];
    logic [15:0]        shadow_d [NSLOT];
    logic [15:0]        out_q    [NSLOT];
    logic [15:0]        out_d    [NSLOT];
    logic [15:0]        adj;
    logic [15:0]        bcd_shift;
    logic               load;

`ifdef MONEY_BCD_LEADING_BLANK_EN
    logic [3:0]         blank_q [NSLOT];
    logic [3:0]         blank_d [NSLOT];

    // A digit blanks when it and every more-significant digit are zero; ones never blanks.
    function automatic logic [3:0] blank_of(input logic [15:0] v);
        logic [3:0] b;
        b[3] = (v[15:12] == 4'd0);
        b[2] = (v[15:8]  == 8'd0);
        b[1] = (v[15:4]  == 12'd0);
        b[0] = 1'b0;
        return b;
    endfunction
`endif

    // Double-dabble step: add 3 to nibbles >= 5, then shift in the binary MSB.
    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
        bcd_shift = 16'({adj, bin_q[VAL_W-1]});
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        slot_d   = slot_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        snap_d   = snap_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        load     = 1'b0;
`ifdef MONEY_BCD_LEADING_BLANK_EN
        blank_d  = blank_q;
`endif

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (frame_start) pend_d = 1'b1;
                bin_d = bin_q << 1;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VAL_W - 1)) begin
                    shadow_d[slot_q] = bcd_shift;
                    cnt_d            = '0;
                    bcd_d            = '0;
                    if (slot_q == SLOT_W'(NSLOT - 1)) begin
                        state_d = COMMIT;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                        bin_d  = snap_q[slot_q + SLOT_W'(1)];
                    end
                end
            end
            COMMIT: begin
                out_d  = shadow_q;
                done_d = 1'b1;
`ifdef MONEY_BCD_LEADING_BLANK_EN
                for (int i = 0; i < NSLOT; i++) blank_d[i] = blank_of(shadow_q[i]);
`endif
                if (pend_q || frame_start) begin
                    pend_d  = 1'b0;
                    load    = 1'b1;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Fresh snapshot, reordered from the viewing player's perspective.
        if (load) begin
            snap_d[0] = player_stacks[current_player];
            snap_d[1] = player_stacks[~current_player];
            snap_d[2] = player_pots[current_player];
            snap_d[3] = player_pots[~current_player];
            snap_d[4] = pot_size;
            bin_d     = player_stacks[current_player];
            bcd_d     = '0;
            cnt_d     = '0;
            slot_d    = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            slot_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            snap_q   <= '{default: '0};
            shadow_q <= '{default: '0};
            out_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            snap_q   <= snap_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

`ifdef MONEY_BCD_LEADING_BLANK_EN
    always_ff @(posedge clk) begin
        if (reset) blank_q <= '{default: 4'b1110};
        else       blank_q <= blank_d;
    end

    assign your_stack_blank  = blank_q[0];
    assign other_stack_blank = blank_q[1];
    assign your_pot_blank    = blank_q[2];
    assign other_pot_blank   = blank_q[3];
    assign total_pot_blank   = blank_q[4];
`else
    assign your_stack_blank  = 4'b0000;
    assign other_stack_blank = 4'b0000;
    assign your_pot_blank    = 4'b0000;
    assign other_pot_blank   = 4'b0000;
    assign total_pot_blank   = 4'b0000;
`endif

    assign your_stack_bcd  = out_q[0];
    assign other_stack_bcd = out_q[1];
    assign your_pot_bcd    = out_q[2];
    assign other_pot_bcd   = out_q[3];
    assign total_pot_bcd   = out_q[4];
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_money_bcd_scheduler.sv
// Scoreboard bench for money_bcd_scheduler: a pass-level model queues expected digits, a monitor checks commits.
module tb_money_bcd_scheduler;

    localparam int unsigned VAL_W    = 11;
    localparam int          PASS_LAT = 5 * VAL_W + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_start;
    logic [VAL_W-1:0] player_stacks [2];
    logic [VAL_W-1:0] player_pots   [2];
    logic [VAL_W-1:0] pot_size;
    logic             current_player;
    logic [15:0]      your_stack_bcd, other_stack_bcd, your_pot_bcd, other_pot_bcd, total_pot_bcd;
    logic [3:0]       your_stack_blank, other_stack_blank, your_pot_blank, other_pot_blank, total_pot_blank;
    logic             busy, done;

    always #5 clk = ~clk;

    money_bcd_scheduler #(.VAL_W(VAL_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_start       (frame_start),
        .player_stacks     (player_stacks),
        .player_pots       (player_pots),
        .pot_size          (pot_size),
        .current_player    (current_player),
        .your_stack_bcd    (your_stack_bcd),
        .other_stack_bcd   (other_stack_bcd),
        .your_pot_bcd      (your_pot_bcd),
        .other_pot_bcd     (other_pot_bcd),
        .total_pot_bcd     (total_pot_bcd),
        .your_stack_blank  (your_stack_blank),
        .other_stack_blank (other_stack_blank),
        .your_pot_blank    (your_pot_blank),
        .other_pot_blank   (other_pot_blank),
        .total_pot_blank   (total_pot_blank),
        .busy              (busy),
        .done              (done)
    );

    typedef struct {
        logic [4:0][15:0] bcd;
        logic [4:0][3:0]  blk;
        int               done_cyc;
    } exp_t;

    exp_t             q[$];
    logic [4:0][15:0] com_bcd;
    logic [4:0][3:0]  com_blk;
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    bit               started = 1'b0;
    logic             exp_busy = 1'b0;
    logic             exp_done = 1'b0;
    bit               m_busy = 1'b0;
    bit               m_pend = 1'b0;
    int               m_commit = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] blank_of(input int v);
`ifdef MONEY_BCD_LEADING_BLANK_EN
        return {v < 1000, v < 100, v < 10, 1'b0};
`else
        return 4'(v * 0);
`endif
    endfunction

    function automatic logic [3:0] rst_blank();
        return blank_of(0);
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected result of a pass started now, from the inputs presented this cycle.
    task automatic start_pass(input int c);
        exp_t e;
        int   v [5];
        v[0] = int'(player_stacks[current_player]);
        v[1] = int'(player_stacks[!current_player]);
        v[2] = int'(player_pots[current_player]);
        v[3] = int'(player_pots[!current_player]);
        v[4] = int'(pot_size);
        for (int i = 0; i < 5; i++) begin
            e.bcd[i] = to_bcd(v[i]);
            e.blk[i] = blank_of(v[i]);
        end
        e.done_cyc = c + PASS_LAT + 1;
        q.push_back(e);
        m_busy   = 1'b1;
        m_commit = c + PASS_LAT;
    endtask

    // Advance one clock; the pass schedule model decides what the coming edge does.
    task automatic step();
        logic nb, nd, rc;
        nd = 1'b0;
        rc = reset;
        if (rc) begin
            m_busy = 1'b0;
            m_pend = 1'b0;
        end else if (!m_busy) begin
            if (frame_start) start_pass(cyc);
        end else if (cyc == m_commit) begin
            nd = 1'b1;
            if (m_pend || frame_start) begin
                m_pend = 1'b0;
                start_pass(cyc);
            end else begin
                m_busy = 1'b0;
            end
        end else if (frame_start) begin
            m_pend = 1'b1;
        end
        nb = m_busy;
        @(posedge clk);
        #1;
        cyc++;
        exp_busy = nb;
        exp_done = nd;
        if (rc) begin
            q.delete();
            com_bcd = '0;
            for (int i = 0; i < 5; i++) com_blk[i] = rst_blank();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_and_run(input int n);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        run(n - 1);
    endtask

    task automatic set_vals(input int s0, input int s1, input int p0, input int p1, input int pot);
        player_stacks[0] = VAL_W'(s0);
        player_stacks[1] = VAL_W'(s1);
        player_pots[0]   = VAL_W'(p0);
        player_pots[1]   = VAL_W'(p1);
        pot_size         = VAL_W'(pot);
    endtask

    always @(negedge clk) begin
        logic [4:0][15:0] gb;
        logic [4:0][3:0]  gk;
        exp_t             e;
        if (started) begin
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy @%0d: got %b expected %b", cyc, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done @%0d: got %b expected %b", cyc, done, exp_done);
            end
            if (done === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected @%0d: got done with empty queue, expected none", cyc);
                end else begin
                    e = q.pop_front();
                    if (e.done_cyc != cyc) begin
                        errors++;
                        $display("FAIL done_cycle: got %0d expected %0d", cyc, e.done_cyc);
                    end
                    com_bcd = e.bcd;
                    com_blk = e.blk;
                end
            end
            gb = {total_pot_bcd, other_pot_bcd, your_pot_bcd, other_stack_bcd, your_stack_bcd};
            gk = {total_pot_blank, other_pot_blank, your_pot_blank, other_stack_blank, your_stack_blank};
            checks++;
            if (gb !== com_bcd || gk !== com_blk) begin
                errors++;
                $display("FAIL outputs @%0d: got %h/%h expected %h/%h", cyc, gb, gk, com_bcd, com_blk);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        frame_start    = 1'b0;
        current_player = 1'b0;
        set_vals(0, 0, 0, 0, 0);
        step();
        started = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        reset = 1'b0;
        run(10);
        chk("reset_your_stack", your_stack_bcd, 16'h0000);
        chk("reset_blank", {12'h000, total_pot_blank}, {12'h000, rst_blank()});

        set_vals(1234, 2047, 5, 999, 1004);
        pulse_and_run(60);
        chk("cp0_your_stack", your_stack_bcd, 16'h1234);
        chk("cp0_other_stack", other_stack_bcd, 16'h2047);
        chk("cp0_your_pot", your_pot_bcd, 16'h0005);
        chk("cp0_other_pot", other_pot_bcd, 16'h0999);
        chk("cp0_total", total_pot_bcd, 16'h1004);

        current_player = 1'b1;
        pulse_and_run(60);
        chk("cp1_your_stack", your_stack_bcd, 16'h2047);
        chk("cp1_your_pot", your_pot_bcd, 16'h0999);
        chk("cp1_total", total_pot_bcd, 16'h1004);

        current_player = 1'b0;
        pulse_and_run(20);
        player_stacks[0] = VAL_W'(7);
        run(40);
        chk("midpass_stack", your_stack_bcd, 16'h1234);
        pulse_and_run(60);
        chk("next_pass_stack", your_stack_bcd, 16'h0007);

        pulse_and_run(10);
        pulse_and_run(20);
        pulse_and_run(100);

        pulse_and_run(30);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midpass_reset", your_stack_bcd, 16'h0000);
        run(5);
        set_vals(42, 1, 100, 8, 2047);
        pulse_and_run(60);
        chk("post_reset_42", your_stack_bcd, 16'h0042);
        chk("blank_42", {12'h000, your_stack_blank}, {12'h000, blank_of(42)});
`ifdef MONEY_BCD_LEADING_BLANK_EN
        chk("blank_42_lit", {12'h000, your_stack_blank}, 16'h000C);
`endif

        for (int i = 0; i < 2500; i++) begin
            reset       = ($urandom_range(0, 599) == 0);
            frame_start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) begin
                current_player = 1'($urandom_range(0, 1));
                set_vals($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                         $urandom_range(0, 2047), $urandom_range(0, 2047));
            end
            step();
        end
        reset       = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < 200 && m_busy; i++) step();
        run(3);
        checks++;
        if (m_busy || q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
